// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared core types for the free list op scheduler
package core_types_pkg;

   // Physical register tag (64 physical registers)
   typedef logic [5:0] phys_reg_tag_t;

   // Dispatch sequencing state: SAVE_PEND means the dequeue already happened
   // and the checkpoint save for the same instruction is still owed.
   typedef enum logic {
      IDLE      = 1'b0,
      SAVE_PEND = 1'b1
   } fl_sched_state_t;

endpackage

// File: rtl/free_list_op_scheduler_if.sv
// rtl/free_list_op_scheduler_if.sv - dispatch/revert/restore/free-list signal bundle
// master: the surrounding pipeline (dispatch, squash walker, restore system, free list)
// slave : the scheduler
interface free_list_op_scheduler_if;
   import core_types_pkg::*;

   logic          disp_dequeue_req;
   logic          disp_save_req;
   logic          disp_grant;
   logic          revert_push_valid;
   phys_reg_tag_t revert_push_tag;
   logic          revert_push_ready;
   logic          revert_busy;
   logic          restore_valid;
   logic          restore_speculate_failed;
   logic          fl_dequeue_valid;
   logic          fl_empty;
   logic          fl_revert_valid;
   phys_reg_tag_t fl_revert_tag;
   logic          fl_save_valid;
   logic          fl_restore_valid;
   logic          sched_error;

   modport master (
      output disp_dequeue_req, disp_save_req, revert_push_valid, revert_push_tag,
             restore_valid, restore_speculate_failed, fl_empty,
      input  disp_grant, revert_push_ready, revert_busy, fl_dequeue_valid,
             fl_revert_valid, fl_revert_tag, fl_save_valid, fl_restore_valid, sched_error
   );

   modport slave (
      input  disp_dequeue_req, disp_save_req, revert_push_valid, revert_push_tag,
             restore_valid, restore_speculate_failed, fl_empty,
      output disp_grant, revert_push_ready, revert_busy, fl_dequeue_valid,
             fl_revert_valid, fl_revert_tag, fl_save_valid, fl_restore_valid, sched_error
   );

endinterface

// File: rtl/revert_tag_fifo.sv
// rtl/revert_tag_fifo.sv - FIFO of speculated phys reg tags awaiting revert
// Ports: CLK, nRST (async active-low), push/push_tag, pop, flush (drops all entries),
//        head_tag (registered array read at read pointer), count, empty.
module revert_tag_fifo
   import core_types_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          push,
   input  phys_reg_tag_t push_tag,
   input  logic          pop,
   input  logic          flush,
   output phys_reg_tag_t head_tag,
   output logic [AW:0]   count,
   output logic          empty
);

   // Pointers carry one extra msb so full and empty are distinguishable
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   phys_reg_tag_t mem [DEPTH];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
   end

   assign head_tag = mem[rd_ptr[AW-1:0]];
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);

endmodule

// File: rtl/free_list_op_scheduler.sv
// rtl/free_list_op_scheduler.sv - serializes free list restore-fail/revert/save/dequeue ops
// Ports: CLK, nRST (async active-low); bus (free_list_op_scheduler_if.slave) carrying the
//        dispatch request/grant, revert tag push, restore request and free list op strobes.
// Priority per cycle: restore-fail > revert > save > dequeue, at most one of them.
// Optional macro FL_SCHED_ERROR_CHECK_EN: sticky sched_error on protocol violations;
// without it sched_error is tied low.
module free_list_op_scheduler
   import core_types_pkg::*;
#(
   parameter int REVERT_FIFO_DEPTH = 8
) (
   input logic                      CLK,
   input logic                      nRST,
   free_list_op_scheduler_if.slave  bus
);

   localparam int          AW       = $clog2(REVERT_FIFO_DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(REVERT_FIFO_DEPTH);

   fl_sched_state_t state, state_next;
   logic            restore_fail;
   logic            full;
   logic            empty;
   logic [AW:0]     count;
   logic            push;
   logic            pop;
   logic            dispatch_ok;
   logic            deq_out;
   logic            save_out;
   logic            grant_out;

   assign restore_fail = bus.restore_valid & bus.restore_speculate_failed;

   // Ready looks at the registered count, so a full FIFO refuses even when popping
   assign full                  = (count == CNT_FULL);
   assign bus.revert_push_ready = ~full & ~restore_fail;
   assign push                  = bus.revert_push_valid & bus.revert_push_ready;
   assign pop                   = ~empty & ~restore_fail;

   revert_tag_fifo #(.DEPTH(REVERT_FIFO_DEPTH)) u_fifo (
      .CLK      (CLK),
      .nRST     (nRST),
      .push     (push),
      .push_tag (bus.revert_push_tag),
      .pop      (pop),
      .flush    (restore_fail),
      .head_tag (bus.fl_revert_tag),
      .count    (count),
      .empty    (empty)
   );

   assign bus.fl_revert_valid  = pop;
   assign bus.revert_busy      = ~empty;
   assign bus.fl_restore_valid = bus.restore_valid;

   // A walker still offering tags also holds dispatch, so a revert always lands
   // before any new allocation from the same free list.
   assign dispatch_ok = ~restore_fail & empty & ~bus.revert_push_valid;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      deq_out    = 1'b0;
      save_out   = 1'b0;
      grant_out  = 1'b0;
      if (restore_fail) begin
         state_next = IDLE;
      end else if (dispatch_ok) begin
         case (state)
            IDLE: begin
               if (bus.disp_dequeue_req && !bus.fl_empty) begin
                  deq_out = 1'b1;
                  // Save follows next cycle so the checkpoint sees this allocation
                  if (bus.disp_save_req) state_next = SAVE_PEND;
                  else                   grant_out  = 1'b1;
               end else if (bus.disp_save_req && !bus.disp_dequeue_req) begin
                  save_out  = 1'b1;
                  grant_out = 1'b1;
               end
            end
            SAVE_PEND: begin
               save_out   = 1'b1;
               grant_out  = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.fl_dequeue_valid = deq_out;
   assign bus.fl_save_valid    = save_out;
   assign bus.disp_grant       = grant_out;

`ifdef FL_SCHED_ERROR_CHECK_EN
   logic err_q;
   logic req_pending_q;
   logic req_any;
   logic multi_op;

   assign req_any  = bus.disp_dequeue_req | bus.disp_save_req;
   assign multi_op = $countones({pop, save_out, deq_out, restore_fail}) > 1;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         err_q         <= 1'b0;
         req_pending_q <= 1'b0;
      end else begin
         err_q <= err_q
                | (bus.revert_push_valid & full)
                | (req_pending_q & ~req_any & ~restore_fail)
                | multi_op;
         req_pending_q <= req_any & ~grant_out & ~restore_fail;
      end
   end

   assign bus.sched_error = err_q;
`else
   assign bus.sched_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_op_scheduler.sv
// tb/tb_free_list_op_scheduler.sv - self-checking bench for free_list_op_scheduler
module tb_free_list_op_scheduler;
   import core_types_pkg::*;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   free_list_op_scheduler_if bus ();

   free_list_op_scheduler #(.REVERT_FIFO_DEPTH(8)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: revert queue plus "save owed" flag
   phys_reg_tag_t m_q[$];
   bit            m_owed;
   bit            m_last_grant;
   bit            m_last_rf;
   bit            e_rf, e_ready, e_busy, e_rev, e_deq, e_save, e_grant, e_blocked;
   phys_reg_tag_t e_tag;
   logic [13:0]   exp_vec, act_vec;

   always @(negedge CLK) begin
      if (!nRST) begin
         m_q.delete();
         m_owed       = 0;
         m_last_grant = 0;
         m_last_rf    = 0;
      end else begin
         e_rf    = bus.restore_valid && bus.restore_speculate_failed;
         e_busy  = m_q.size() != 0;
         e_ready = (m_q.size() < 8) && !e_rf;
         e_rev   = e_busy && !e_rf;
         e_tag   = e_rev ? m_q[0] : '0;
         e_deq   = 0;
         e_save  = 0;
         e_grant = 0;
         e_blocked = e_rf || e_busy || bus.revert_push_valid;
         if (!e_blocked) begin
            if (m_owed) begin
               e_save = 1; e_grant = 1;
            end else if (bus.disp_dequeue_req && !bus.fl_empty) begin
               e_deq = 1;
               e_grant = !bus.disp_save_req;
            end else if (bus.disp_save_req && !bus.disp_dequeue_req) begin
               e_save = 1; e_grant = 1;
            end
         end
         exp_vec = {bus.restore_valid, e_ready, e_busy, e_rev, e_tag, e_deq, e_save, e_grant, 1'b0};
         act_vec = {bus.fl_restore_valid, bus.revert_push_ready, bus.revert_busy, bus.fl_revert_valid,
                    bus.fl_revert_valid ? bus.fl_revert_tag : 6'd0,
                    bus.fl_dequeue_valid, bus.fl_save_valid, bus.disp_grant, bus.sched_error};
         chk("cycle_outputs", 32'(act_vec), 32'(exp_vec));
         // advance model
         if (e_rf) begin
            m_q.delete();
            m_owed = 0;
         end else begin
            if (e_rev) void'(m_q.pop_front());
            if (bus.revert_push_valid && e_ready) m_q.push_back(bus.revert_push_tag);
            if (e_save) m_owed = 0;
            else if (e_deq && bus.disp_save_req) m_owed = 1;
         end
         m_last_grant = e_grant;
         m_last_rf    = e_rf;
      end
   end

   task automatic drive(input bit deq, input bit sav, input bit pv, input int tag,
                        input bit rv, input bit sf, input bit fe);
      @(posedge CLK); #1;
      bus.disp_dequeue_req         = deq;
      bus.disp_save_req            = sav;
      bus.revert_push_valid        = pv;
      bus.revert_push_tag          = phys_reg_tag_t'(tag);
      bus.restore_valid            = rv;
      bus.restore_speculate_failed = sf;
      bus.fl_empty                 = fe;
      #2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"},  32'(bus.disp_grant), 0);
      chk({tag, "_deq"},    32'(bus.fl_dequeue_valid), 0);
      chk({tag, "_save"},   32'(bus.fl_save_valid), 0);
      chk({tag, "_rev"},    32'(bus.fl_revert_valid), 0);
      chk({tag, "_busy"},   32'(bus.revert_busy), 0);
      chk({tag, "_ready"},  32'(bus.revert_push_ready), 1);
      chk({tag, "_err"},    32'(bus.sched_error), 0);
      chk({tag, "_restore"},32'(bus.fl_restore_valid), 0);
   endtask

   bit req_deq, req_sav;

   initial begin
      bus.disp_dequeue_req = 0; bus.disp_save_req = 0; bus.revert_push_valid = 0;
      bus.revert_push_tag = '0; bus.restore_valid = 0; bus.restore_speculate_failed = 0;
      bus.fl_empty = 0;
      repeat (2) @(posedge CLK);
      #1 chk_reset_outputs("reset");
      nRST = 1;

      // dequeue then save
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("ds_c1_deq", 32'(bus.fl_dequeue_valid), 1);
      chk("ds_c1_grant", 32'(bus.disp_grant), 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("ds_c2_save", 32'(bus.fl_save_valid), 1);
      chk("ds_c2_grant", 32'(bus.disp_grant), 1);
      chk("ds_c2_deq", 32'(bus.fl_dequeue_valid), 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      // three back-to-back reverts, dispatch held
      drive(1, 0, 1, 40, 0, 0, 0);
      chk("rv_c0_grant", 32'(bus.disp_grant), 0);
      drive(1, 0, 1, 41, 0, 0, 0);
      chk("rv_c1_tag", 32'({bus.fl_revert_valid, bus.fl_revert_tag}), 32'({1'b1, 6'd40}));
      drive(1, 0, 1, 42, 0, 0, 0);
      chk("rv_c2_tag", 32'({bus.fl_revert_valid, bus.fl_revert_tag}), 32'({1'b1, 6'd41}));
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("rv_c3_tag", 32'({bus.fl_revert_valid, bus.fl_revert_tag}), 32'({1'b1, 6'd42}));
      chk("rv_c3_grant", 32'(bus.disp_grant), 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("rv_c4_deq_grant", 32'({bus.fl_revert_valid, bus.fl_dequeue_valid, bus.disp_grant}), 32'b011);
      drive(0, 0, 0, 0, 0, 0, 0);

      // SAVE_PEND interrupted by revert of tag 37
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("sp_c1_deq", 32'(bus.fl_dequeue_valid), 1);
      drive(1, 1, 1, 37, 0, 0, 0);
      chk("sp_c2_idle", 32'({bus.fl_save_valid, bus.disp_grant, bus.fl_dequeue_valid}), 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("sp_c3_tag", 32'({bus.fl_revert_valid, bus.fl_revert_tag, bus.fl_save_valid}), 32'({1'b1, 6'd37, 1'b0}));
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("sp_c4_save_grant", 32'({bus.fl_save_valid, bus.disp_grant}), 32'b11);
      drive(0, 0, 0, 0, 0, 0, 0);

      // restore-fail flushes FIFO, drops push, returns FSM to IDLE
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 10, 0, 0, 0);
      drive(1, 1, 1, 11, 0, 0, 0);
      drive(1, 1, 1, 12, 1, 1, 0);
      chk("rf_only_restore", 32'({bus.fl_restore_valid, bus.fl_revert_valid, bus.fl_save_valid,
                                  bus.fl_dequeue_valid, bus.disp_grant}), 32'b10000);
      chk("rf_push_ready", 32'(bus.revert_push_ready), 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("rf_next_busy", 32'({bus.revert_busy, bus.fl_revert_valid}), 0);
      chk("rf_next_idle_deq", 32'({bus.fl_dequeue_valid, bus.fl_save_valid}), 32'b10);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("rf_then_save", 32'({bus.fl_save_valid, bus.disp_grant}), 32'b11);
      drive(0, 0, 0, 0, 0, 0, 0);

      // dequeue stalls on empty free list
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 0, 0, 1);
         chk("empty_stall", 32'({bus.fl_dequeue_valid, bus.disp_grant}), 0);
      end
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("empty_release", 32'({bus.fl_dequeue_valid, bus.disp_grant}), 32'b11);

      // restore invalidate does not block a save
      drive(0, 1, 0, 0, 1, 0, 0);
      chk("inval_orthogonal", 32'({bus.fl_restore_valid, bus.fl_save_valid, bus.disp_grant}), 32'b111);
      drive(0, 0, 0, 0, 0, 0, 0);

      // randomized phase, with one asynchronous reset mid-run
      req_deq = 0; req_sav = 0;
      for (int i = 0; i < 1500; i++) begin
         @(posedge CLK); #1;
         if (i == 700) begin
            nRST = 0;
            bus.disp_dequeue_req = 0; bus.disp_save_req = 0; bus.revert_push_valid = 0;
            bus.restore_valid = 0; bus.restore_speculate_failed = 0;
            req_deq = 0; req_sav = 0;
            #1 chk_reset_outputs("midreset");
            @(posedge CLK); #1 nRST = 1;
            continue;
         end
         if (m_last_grant || m_last_rf) begin
            req_deq = 0; req_sav = 0;
         end
         if (!req_deq && !req_sav && ($urandom % 3 == 0)) begin
            case ($urandom % 3)
               0: req_deq = 1;
               1: req_sav = 1;
               default: begin req_deq = 1; req_sav = 1; end
            endcase
         end
         bus.disp_dequeue_req         = req_deq;
         bus.disp_save_req            = req_sav;
         bus.revert_push_valid        = ($urandom % 4 == 0);
         bus.revert_push_tag          = phys_reg_tag_t'($urandom);
         bus.restore_valid            = ($urandom % 8 == 0);
         bus.restore_speculate_failed = ($urandom % 3 == 0);
         bus.fl_empty                 = ($urandom % 4 == 0);
      end

      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
